// File: rtl/regfile_access_ctrl.sv
// Bank-side sequencer for a register file: one write and/or one dual read per transaction, write first.
// Optional macro REGFILE_ADDR_ERR_EN adds the AddrErr output for out-of-range addresses.
module regfile_access_ctrl #(
  parameter int N  = 16,
  parameter int R  = 16,
  parameter int AW = 4
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          WrReq,
  input  logic [AW-1:0] WrAddr,
  input  logic [N-1:0]  WrData,
  input  logic          RdReq,
  input  logic [AW-1:0] RdAddrA,
  input  logic [AW-1:0] RdAddrB,
  output logic          Ready,
  output logic [R-1:0]  Ld,
  output logic [N-1:0]  WData,
  output logic [R-1:0]  Oea,
  output logic [R-1:0]  Oeb,
  input  logic [N-1:0]  BusA,
  input  logic [N-1:0]  BusB,
  output logic [N-1:0]  DataA,
  output logic [N-1:0]  DataB,
  output logic          RdValid
`ifdef REGFILE_ADDR_ERR_EN
  ,
  output logic          AddrErr
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [AW:0] R_LIM = R[AW:0];

  state_t        state_r;
  state_t        state_s;
  logic          wr_req_r;
  logic          rd_req_r;
  logic [AW-1:0] wr_addr_r;
  logic [N-1:0]  wr_data_r;
  logic [AW-1:0] rd_addr_a_r;
  logic [AW-1:0] rd_addr_b_r;
  logic [N-1:0]  data_a_r;
  logic [N-1:0]  data_b_r;

  function automatic logic in_range(input logic [AW-1:0] a);
    return ({1'b0, a} < R_LIM);
  endfunction

  // Out-of-range addresses match no bit, so the vector stays all-zero.
  function automatic logic [R-1:0] decode_onehot(input logic [AW-1:0] a);
    logic [R-1:0] v;
    v = {R{1'b0}};
    for (int i = 0; i < R; i++) begin
      if ({1'b0, a} == i[AW:0]) begin
        v[i] = 1'b1;
      end else begin
        v[i] = 1'b0;
      end
    end
    return v;
  endfunction

  // State register.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state and enable decode; enables come only from registered state and latched requests.
  always_comb begin
    state_s = state_r;
    Ready   = 1'b0;
    Ld      = {R{1'b0}};
    Oea     = {R{1'b0}};
    Oeb     = {R{1'b0}};
    WData   = {N{1'b0}};
    RdValid = 1'b0;
    case (state_r)
      ST_IDLE: begin
        Ready = 1'b1;
        if (WrReq) begin
          state_s = ST_WRITE;
        end else if (RdReq) begin
          state_s = ST_READ;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WRITE: begin
        Ld    = decode_onehot(wr_addr_r);
        WData = wr_data_r;
        if (rd_req_r) begin
          state_s = ST_READ;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_READ: begin
        Oea     = decode_onehot(rd_addr_a_r);
        Oeb     = decode_onehot(rd_addr_b_r);
        state_s = ST_DONE;
      end
      ST_DONE: begin
        RdValid = 1'b1;
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Request latch, loaded only when a request is accepted in IDLE.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_req_r    <= 1'b0;
      rd_req_r    <= 1'b0;
      wr_addr_r   <= {AW{1'b0}};
      wr_data_r   <= {N{1'b0}};
      rd_addr_a_r <= {AW{1'b0}};
      rd_addr_b_r <= {AW{1'b0}};
    end else if ((state_r == ST_IDLE) && (WrReq || RdReq)) begin
      wr_req_r    <= WrReq;
      rd_req_r    <= RdReq;
      wr_addr_r   <= WrAddr;
      wr_data_r   <= WrData;
      rd_addr_a_r <= RdAddrA;
      rd_addr_b_r <= RdAddrB;
    end
  end

  // Read capture; an out-of-range channel reads 0 instead of the floating bus.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      data_a_r <= {N{1'b0}};
      data_b_r <= {N{1'b0}};
    end else if (state_r == ST_READ) begin
      data_a_r <= in_range(rd_addr_a_r) ? BusA : {N{1'b0}};
      data_b_r <= in_range(rd_addr_b_r) ? BusB : {N{1'b0}};
    end
  end

  assign DataA = data_a_r;
  assign DataB = data_b_r;

`ifdef REGFILE_ADDR_ERR_EN
  logic addr_err_r;

  // Error pulse lands in the transaction's final cycle: DONE, or the IDLE after a lone WRITE.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      addr_err_r <= 1'b0;
    end else if ((state_r == ST_WRITE) && !rd_req_r) begin
      addr_err_r <= !in_range(wr_addr_r);
    end else if (state_r == ST_READ) begin
      addr_err_r <= (wr_req_r && !in_range(wr_addr_r)) ||
                    !in_range(rd_addr_a_r) || !in_range(rd_addr_b_r);
    end else begin
      addr_err_r <= 1'b0;
    end
  end

  assign AddrErr = addr_err_r;
`endif

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed bench for regfile_access_ctrl (R=12) with a behavioural tri-state register bank model.
module tb_regfile_access_ctrl;
  localparam int N  = 16;
  localparam int R  = 12;
  localparam int AW = 4;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          WrReq;
  logic [AW-1:0] WrAddr;
  logic [N-1:0]  WrData;
  logic          RdReq;
  logic [AW-1:0] RdAddrA;
  logic [AW-1:0] RdAddrB;
  logic          Ready;
  logic [R-1:0]  Ld;
  logic [N-1:0]  WData;
  logic [R-1:0]  Oea;
  logic [R-1:0]  Oeb;
  logic [N-1:0]  BusA;
  logic [N-1:0]  BusB;
  logic [N-1:0]  DataA;
  logic [N-1:0]  DataB;
  logic          RdValid;
`ifdef REGFILE_ADDR_ERR_EN
  logic          AddrErr;
`endif

  logic [N-1:0]  bank [R];
  logic [R-1:0]  ld_seen;
  int            check_cnt = 0;
  int            err_cnt   = 0;

  regfile_access_ctrl #(.N(N), .R(R), .AW(AW)) dut (
    .Clk(Clk), .Rst(Rst),
    .WrReq(WrReq), .WrAddr(WrAddr), .WrData(WrData),
    .RdReq(RdReq), .RdAddrA(RdAddrA), .RdAddrB(RdAddrB),
    .Ready(Ready), .Ld(Ld), .WData(WData), .Oea(Oea), .Oeb(Oeb),
    .BusA(BusA), .BusB(BusB), .DataA(DataA), .DataB(DataB),
    .RdValid(RdValid)
`ifdef REGFILE_ADDR_ERR_EN
    , .AddrErr(AddrErr)
`endif
  );

  always #5 Clk = ~Clk;

  // Bank model: shares Rst, loads on Ld, floating bus reads back as 16'hDEAD.
  always @(posedge Clk) begin
    for (int i = 0; i < R; i++) begin
      if (Rst) bank[i] <= '0;
      else if (Ld[i]) bank[i] <= WData;
    end
  end

  always_comb begin
    BusA = 16'hDEAD;
    BusB = 16'hDEAD;
    for (int j = 0; j < R; j++) begin
      if (Oea[j]) BusA = bank[j];
      if (Oeb[j]) BusB = bank[j];
    end
  end

  always @(negedge Clk) ld_seen <= ld_seen | Ld;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Present a request at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic wr, input logic [AW-1:0] wa, input logic [N-1:0] wd,
                       input logic rd, input logic [AW-1:0] ra, input logic [AW-1:0] rb);
    WrReq = wr; WrAddr = wa; WrData = wd;
    RdReq = rd; RdAddrA = ra; RdAddrB = rb;
    @(negedge Clk);
    WrReq = 1'b0; RdReq = 1'b0;
  endtask

  initial begin
    Rst = 1'b1; WrReq = 1'b0; RdReq = 1'b0;
    WrAddr = '0; WrData = '0; RdAddrA = '0; RdAddrB = '0;
    ld_seen = '0;
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    check("rst_ready", 32'(Ready), 32'd1);
    check("rst_ld", 32'(Ld), 32'h0);
    check("rst_oea", 32'(Oea | Oeb), 32'h0);
    check("rst_data", {DataA, DataB}, 32'h0);
    check("rst_rdvalid", 32'(RdValid), 32'd0);

    // Write-only
    issue(1'b1, 4'd3, 16'hBEEF, 1'b0, 4'd0, 4'd0);
    check("wo_ld", 32'(Ld), 32'h008);
    check("wo_wdata", 32'(WData), 32'hBEEF);
    check("wo_ready", 32'(Ready), 32'd0);
    @(negedge Clk);
    check("wo_ready2", 32'(Ready), 32'd1);
    check("wo_bank3", 32'(bank[3]), 32'hBEEF);
    check("wo_rdvalid", 32'(RdValid), 32'd0);

    // Write+read, same address
    issue(1'b1, 4'd5, 16'h1234, 1'b1, 4'd5, 4'd0);
    check("wr_ld", 32'(Ld), 32'h020);
    check("wr_oe_in_write", 32'(Oea | Oeb), 32'h0);
    @(negedge Clk);
    check("wr_oea", 32'(Oea), 32'h020);
    check("wr_oeb", 32'(Oeb), 32'h001);
    check("wr_ld_in_read", 32'(Ld), 32'h0);
    check("wr_rdvalid_early", 32'(RdValid), 32'd0);
    @(negedge Clk);
    check("wr_rdvalid", 32'(RdValid), 32'd1);
    check("wr_data", {DataA, DataB}, {16'h1234, 16'h0000});
    @(negedge Clk);
    check("wr_rdvalid_end", 32'(RdValid), 32'd0);
    check("wr_ready_end", 32'(Ready), 32'd1);

    // Busy drop: write offered during READ/DONE must be ignored
    issue(1'b0, 4'd0, 16'h0, 1'b1, 4'd1, 4'd1);
    ld_seen = '0;
    WrReq = 1'b1; WrAddr = 4'd2; WrData = 16'hFFFF;
    @(negedge Clk);
    check("busy_rdvalid", 32'(RdValid), 32'd1);
    @(negedge Clk);
    WrReq = 1'b0;
    repeat (3) @(negedge Clk);
    check("busy_no_ld", 32'(ld_seen), 32'h0);
    check("busy_bank2", 32'(bank[2]), 32'h0);

    // Same-address dual read
    issue(1'b1, 4'd7, 16'hA5A5, 1'b0, 4'd0, 4'd0);
    @(negedge Clk);
    issue(1'b0, 4'd0, 16'h0, 1'b1, 4'd7, 4'd7);
    check("dual_oea", 32'(Oea), 32'h080);
    check("dual_oeb", 32'(Oeb), 32'h080);
    @(negedge Clk);
    check("dual_rdvalid", 32'(RdValid), 32'd1);
    check("dual_data", {DataA, DataB}, {16'hA5A5, 16'hA5A5});
    @(negedge Clk);
    check("dual_pulse_1cyc", 32'(RdValid), 32'd0);
    check("dual_hold", 32'(DataA), 32'hA5A5);

    // Reset during WRITE
    issue(1'b1, 4'd4, 16'h4444, 1'b0, 4'd0, 4'd0);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    check("mid_rst_ld", 32'(Ld), 32'h0);
    check("mid_rst_ready", 32'(Ready), 32'd1);
    check("mid_rst_data", {DataA, DataB}, 32'h0);
    check("mid_rst_rdvalid", 32'(RdValid), 32'd0);
    check("mid_rst_bank4", 32'(bank[4]), 32'h0);

    // Out of range (R=12)
    issue(1'b1, 4'd2, 16'h0C0C, 1'b1, 4'd2, 4'd2);
    repeat (3) @(negedge Clk);
    check("oor_pre_dataa", 32'(DataA), 32'h0C0C);
    issue(1'b0, 4'd0, 16'h0, 1'b1, 4'd14, 4'd2);
    check("oor_oea", 32'(Oea), 32'h0);
    check("oor_oeb", 32'(Oeb), 32'h004);
    @(negedge Clk);
    check("oor_rdvalid", 32'(RdValid), 32'd1);
    check("oor_data", {DataA, DataB}, {16'h0000, 16'h0C0C});
`ifdef REGFILE_ADDR_ERR_EN
    check("oor_addrerr", 32'(AddrErr), 32'd1);
`endif
    @(negedge Clk);
`ifdef REGFILE_ADDR_ERR_EN
    check("oor_addrerr_end", 32'(AddrErr), 32'd0);
`endif
    ld_seen = '0;
    issue(1'b1, 4'd13, 16'h5555, 1'b0, 4'd0, 4'd0);
    check("oor_wr_ld", 32'(Ld), 32'h0);
    check("oor_wr_ready", 32'(Ready), 32'd0);
    @(negedge Clk);
    check("oor_wr_ready2", 32'(Ready), 32'd1);
    check("oor_wr_no_ld", 32'(ld_seen), 32'h0);
`ifdef REGFILE_ADDR_ERR_EN
    check("oor_wr_addrerr", 32'(AddrErr), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
    $finish;
  end
endmodule
